register_file_legv8: RTL and testbench



---
 rtl/legv8_pkg.sv | 20 ++
 rtl/register_file_read_port.sv | 49 ++++
 rtl/register_file_legv8.sv | 66 ++++++
 tb/tb_register_file_legv8.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 widths, register address constants and typedefs
// Purpose: common types for register file, ALU, decode and datapath.
// Ports: none (package).
package legv8_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

  localparam reg_addr_t XZR_ADDR = 5'd31;

  // True when the address names the hardwired-zero register.
  function automatic logic is_xzr(input reg_addr_t addr);
    return addr == XZR_ADDR;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// rtl/register_file_read_port.sv - one combinational 32:1 read port with XZR zero and optional bypass
// Purpose: selects one of X0..X30, forces zero for X31 and while reset is held.
// Optional feature: REGFILE_BYPASS_EN forwards the pending write data when the
// read address matches the write address in the same cycle.
// Ports:
//   i_regs    - storage contents X0..X30
//   i_rst_n   - active-low reset level (forces zero, suppresses forwarding)
//   i_sel     - read address
//   i_we      - pending write enable
//   i_wa      - pending write address
//   i_wd      - pending write data
//   o_rdata   - read data
module register_file_read_port
  import legv8_pkg::*;
(
  input  xword_t    i_regs [0:NREG-2],
  input  logic      i_rst_n,
  input  reg_addr_t i_sel,
  input  logic      i_we,
  input  reg_addr_t i_wa,
  input  xword_t    i_wd,
  output xword_t    o_rdata
);

`ifdef REGFILE_BYPASS_EN
  logic w_fwd;
  assign w_fwd = i_we && (i_wa == i_sel) && !is_xzr(i_wa);
`else
  // Write-side inputs only matter when forwarding is built in.
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_we, i_wa, i_wd};
`endif

  always_comb begin
    o_rdata = '0;
    if (!i_rst_n || is_xzr(i_sel)) begin
      o_rdata = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (w_fwd) begin
      o_rdata = i_wd;
    end
`endif
    else begin
      o_rdata = i_regs[i_sel];
    end
  end

endmodule

// File: rtl/register_file_legv8.sv
// rtl/register_file_legv8.sv - LEGv8 32x64 register file, two async read ports, one sync write port
// Purpose: architectural registers X0..X30 plus hardwired-zero X31 (XZR).
// Optional feature: REGFILE_BYPASS_EN (same-cycle write-through forwarding).
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset, clears X0..X30
//   SA, SB  - read addresses for ports A and B
//   DA      - write address
//   W       - write enable
//   D       - write data
//   A, B    - read data for ports A and B
module register_file_legv8
  import legv8_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREG_P = NREG
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [4:0]      SA,
  input  logic [4:0]      SB,
  input  logic [4:0]      DA,
  input  logic            W,
  input  logic [XLEN-1:0] D,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B
);

  // Width and count are fixed by the ISA; the parameters exist for documentation only.
  logic w_unused_params;
  assign w_unused_params = (XLEN_P != XLEN) || (NREG_P != NREG);

  xword_t r_regs [0:NREG-2];

  // An X on W falls to the else path of "if (W)", so storage is left alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG - 1; i++) begin
        r_regs[i] <= '0;
      end
    end else if (W && !is_xzr(DA)) begin
      r_regs[DA] <= D;
    end
  end

  register_file_read_port u_port_a (
    .i_regs  (r_regs),
    .i_rst_n (reset_n),
    .i_sel   (SA),
    .i_we    (W),
    .i_wa    (DA),
    .i_wd    (D),
    .o_rdata (A)
  );

  register_file_read_port u_port_b (
    .i_regs  (r_regs),
    .i_rst_n (reset_n),
    .i_sel   (SB),
    .i_we    (W),
    .i_wa    (DA),
    .i_wd    (D),
    .o_rdata (B)
  );

endmodule

// File: tb/tb_register_file_legv8.sv
// tb/tb_register_file_legv8.sv - self-checking bench for register_file_legv8 against a behavioural model
module tb_register_file_legv8;

  logic        clock;
  logic        reset_n;
  logic [4:0]  SA, SB, DA;
  logic        W;
  logic [63:0] D;
  logic [63:0] A, B;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: 32 architectural values, entry 31 never written.
  logic [63:0] m [0:31];
  logic        m_rst;

  register_file_legv8 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .SA      (SA),
    .SB      (SB),
    .DA      (DA),
    .W       (W),
    .D       (D),
    .A       (A),
    .B       (B)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] a);
    if (m_rst || a == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (W && DA != 5'd31 && DA == a) return D;
`endif
    return m[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = 64'd0;
  endtask

  // Drive a write from the negative edge, commit it at the rising edge.
  task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
    W = 1'b1; DA = addr; D = data;
    @(posedge clock);
    if (!m_rst && addr != 5'd31) m[addr] = data;
    @(negedge clock);
    W = 1'b0;
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, "_A"}, A, model_read(SA));
    check({tag, "_B"}, B, model_read(SB));
  endtask

  initial begin
    reset_n = 1'b0; m_rst = 1'b1;
    W = 1'b0; DA = 5'd0; D = 64'd0; SA = 5'd0; SB = 5'd0;
    model_clear();

    // 1. Reset sweep, then release and sweep again.
    #2;
    for (int i = 0; i < 32; i++) begin
      SA = 5'(i); SB = 5'(31 - i);
      #1;
      check("rst_hold_A", A, 64'd0);
      check("rst_hold_B", B, 64'd0);
    end
    @(negedge clock);
    reset_n = 1'b1; m_rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      SA = 5'(i); SB = 5'(i);
      #1;
      check("post_rst_A", A, 64'd0);
      check("post_rst_B", B, 64'd0);
    end
    @(negedge clock);

    // 2. Basic write/read.
    do_write(5'd5, 64'hDEADBEEF_01234567);
    SA = 5'd5; SB = 5'd5; #1;
    check("wr5_A", A, 64'hDEADBEEF_01234567);
    check("wr5_B", B, 64'hDEADBEEF_01234567);
    SA = 5'd6; #1;
    check("rd6_A", A, 64'd0);

    // 3. XZR ignores writes; other registers unchanged.
    @(negedge clock);
    do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    SA = 5'd31; SB = 5'd5; #1;
    check("xzr_A", A, 64'd0);
    check("xzr_keep5_B", B, 64'hDEADBEEF_01234567);
    for (int i = 0; i < 31; i++) begin
      SA = 5'(i); #1;
      check("xzr_others", A, m[i]);
    end

    // 4. Same-cycle read of the register being written.
    @(negedge clock);
    do_write(5'd7, 64'h1);
    W = 1'b1; DA = 5'd7; D = 64'h2; SA = 5'd7; SB = 5'd7; #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cyc_A", A, 64'h2);
`else
    check("same_cyc_A", A, 64'h1);
`endif
    @(posedge clock);
    m[7] = 64'h2;
    @(negedge clock);
    W = 1'b0; #1;
    check("after_edge_A", A, 64'h2);
    check("after_edge_B", B, 64'h2);

    // 5. Asynchronous reset between edges, then a blocked write.
    @(negedge clock);
    do_write(5'd3, 64'hA5A5);
    SA = 5'd3; SB = 5'd7; #1;
    check("x3_A", A, 64'hA5A5);
    #1;
    reset_n = 1'b0; m_rst = 1'b1; model_clear();
    #1;
    check("async_rst_A", A, 64'd0);
    check("async_rst_B", B, 64'd0);
    @(negedge clock);
    do_write(5'd3, 64'h55);
    #1;
    check("rst_wr_blk_A", A, 64'd0);
    reset_n = 1'b1; m_rst = 1'b0;
    #1;
    check("rst_released_A", A, 64'd0);
    check("rst_released_B", B, 64'd0);

    // 6. Random sweep against the model.
    @(negedge clock);
    for (int c = 0; c < 2000; c++) begin
      W  = 1'($urandom_range(0, 1));
      DA = 5'($urandom_range(0, 31));
      D  = {$urandom, $urandom};
      SA = ($urandom_range(0, 3) == 0) ? DA : 5'($urandom_range(0, 31));
      SB = ($urandom_range(0, 3) == 0) ? DA : 5'($urandom_range(0, 31));
      check_ports("rand");
      @(posedge clock);
      if (W && DA != 5'd31) m[DA] = D;
      @(negedge clock);
      W = 1'b0;
      check_ports("rand_post");
    end

    // ALU-style use: X1 + X2 through the two ports.
    do_write(5'd1, 64'd3);
    do_write(5'd2, 64'd4);
    SA = 5'd1; SB = 5'd2; #1;
    check("alu_add_F", A + B, 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
